multicycle_rv_core: RTL and testbench
=====================================

Name: multicycle_rv_core

Overview:
Parametrised multi-cycle successor to the single-cycle board CPU. It executes an RV32I integer subset through a FETCH/DECODE/EXEC/WB state machine, with a handshaked instruction-memory port and a run/single-step debug control. The register file and ALU are internal. Debug read-out drives the board 7-segment displays.

Parameters:
XLEN, 32, datapath/register/PC width (16..32)
NREGS, 32, architectural registers implemented (power of 2, 2..32)
IMEM_AW, 8, instruction-memory word-address width
PC_RESET, 0, PC value after reset (word aligned)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  1 = free-running execution
step  in  1  level input; a rising edge executes one instruction when run=0
imem_req  out  1  fetch request, held until imem_valid
imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
imem_rdata  in  32  instruction word
imem_valid  in  1  imem_rdata valid; sampled only while imem_req=1
pc  out  XLEN  current PC
retire  out  1  one-cycle pulse per completed instruction
wb_en  out  1  register write this cycle
wb_addr  out  5  destination register
wb_data  out  XLEN  written value
halted  out  1  core stopped (ECALL or illegal)
illegal  out  1  sticky; halt was caused by an illegal instruction
dbg_sel  in  5  debug register select
dbg_data  out  XLEN  combinational register-file read; 0 when dbg_sel=0 or dbg_sel>=NREGS

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, pc=PC_RESET, all registers 0.
  - imem_req, retire, wb_en, halted, illegal all 0.
  - imem_req drops immediately, even mid-fetch.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE:
  - Go to FETCH if run=1, or if a step rising edge is detected (internal registered edge detector).
  - run=1 takes priority over step.
- FETCH:
  - imem_req=1.
  - When imem_valid=1, latch imem_rdata into IR and go to DECODE.
  - A zero-wait memory (valid in the same cycle as req) gives 1 cycle; otherwise stall indefinitely.
- DECODE:
  - Read rs1/rs2 into operand latches A/B; sign-extend the I-immediate to XLEN.
  - Legality check:
    - Illegal if opcode is unsupported, funct bits are unsupported, or any used register index is >= NREGS.
    - Illegal -> HALT with illegal=1.
    - ECALL (0x00000073) -> HALT with illegal=0.
- EXEC:
  - ALU result is latched.
  - R-type: ADD, SUB (funct7=0100000), AND, OR, XOR, SLT (signed), SLTU.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI.
  - Arithmetic wraps mod 2^XLEN; SLT/SLTU produce 1 or 0.
- WB:
  - If rd!=0: wb_en=1 and the register file is written. Writes to x0 are suppressed (wb_en=0) but the instruction still retires.
  - pc <= pc+4, wrapping mod 2^XLEN; imem_addr wraps at 2^IMEM_AW.
  - retire=1 for this one cycle.
  - Next state: FETCH if run=1, else IDLE.
- CPI = 4 at zero wait states.
- HALT:
  - halted=1; run and step are ignored.
  - Exit only via reset.
  - pc holds the address of the halting instruction.
- Timing and boundaries:
  - A step edge arriving while not in IDLE is discarded, not queued.
  - Dropping run mid-instruction completes that instruction, then the core parks in IDLE.
  - dbg_data reflects a WB write from the following cycle.

Optional Feature:
- Macro BRANCH_EN.
- Defined:
  - BEQ/BNE are legal. Comparison happens in EXEC; the B-immediate is sign-extended.
  - Taken: pc <= pc+imm. Not taken: pc <= pc+4.
  - No register write; retire still pulses in WB.
- Undefined: opcode 1100011 is illegal -> HALT with illegal=1.

Test Plan:
- Reset with PC_RESET=0, run=1; memory holds ADDI x1,x0,5 then ADDI x2,x0,-3 at zero wait.
  -> retire at cycles 4 and 8; wb_data=5 then 0xFFFFFFFD; dbg_sel=2 reads 0xFFFFFFFD.
- x1=5, x2=-3; execute SLT x3,x1,x2 then SLTU x4,x1,x2 then SUB x5,x1,x2.
  -> x3=0, x4=1, x5=8.
- run=0; pulse step twice while holding step=1 for 10 cycles each time.
  -> exactly 2 retires; pc=PC_RESET+8; state IDLE.
- imem_valid delayed 3 cycles on each fetch.
  -> imem_req held 4 cycles; CPI=7; results unchanged.
- Word 0xFFFFFFFF, then ECALL in a separate run, then ADDI x0,x0,7.
  -> halted=1, illegal=1 and pc unchanged; for ECALL halted=1, illegal=0; for ADDI x0 wb_en=0, retire=1, dbg_data(0)=0.
- BRANCH_EN defined; BEQ x0,x0,-8 at pc=0x10.
  -> next fetch imem_addr=2 (pc=0x08); without BRANCH_EN, illegal=1.

Source files
------------

// File: rtl/multicycle_rv_core.sv
// multicycle_rv_core: multi-cycle RV32I-subset core (FETCH/DECODE/EXEC/WB) with handshaked imem and run/step debug control.
// Optional macro BRANCH_EN enables BEQ/BNE; when undefined, opcode 1100011 halts the core as illegal.
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   run, step                           free-run enable; rising step edge runs one instruction from IDLE
//   imem_req/imem_addr/imem_rdata/imem_valid  instruction fetch handshake (word addressed)
//   pc                                  current PC
//   retire, wb_en, wb_addr, wb_data     per-instruction retire pulse and register write-back
//   halted, illegal                     halt status (ECALL or illegal instruction)
//   dbg_sel, dbg_data                   combinational register-file read-out for the displays
module multicycle_rv_core #(
    parameter int          XLEN     = 32,
    parameter int          NREGS    = 32,
    parameter int          IMEM_AW  = 8,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_valid,
    output logic [XLEN-1:0]    pc,
    output logic               retire,
    output logic               wb_en,
    output logic [4:0]         wb_addr,
    output logic [XLEN-1:0]    wb_data,
    output logic               halted,
    output logic               illegal,
    input  logic [4:0]         dbg_sel,
    output logic [XLEN-1:0]    dbg_data
);
    localparam int         AW = $clog2(NREGS);
    localparam logic [5:0] NR = 6'(NREGS);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] a, b, npc, next_pc, imm_i, addsub, alu;
    logic [XLEN-1:0] regs [NREGS];
    logic            step_q;
    logic [6:0]      opcode, f7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic            is_op, is_imm, is_br, funct_ok, bad_reg, legal;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];
    assign is_op  = opcode == 7'b0110011;
    assign is_imm = opcode == 7'b0010011;
    assign imm_i  = {{(XLEN-12){ir[31]}}, ir[31:20]};

`ifdef BRANCH_EN
    assign is_br   = opcode == 7'b1100011;
    // f3[0] distinguishes BNE from BEQ, so it simply inverts the equality test
    assign next_pc = (is_br && ((a == b) ^ f3[0]))
                   ? pc + {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}
                   : pc + XLEN'(4);
`else
    assign is_br   = 1'b0;
    assign next_pc = pc + XLEN'(4);
`endif

    assign funct_ok = is_op  ? ((f7 == 7'b0000000 && f3 != 3'b001 && f3 != 3'b101) ||
                                (f7 == 7'b0100000 && f3 == 3'b000))
                    : is_imm ? (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b100 ||
                                f3 == 3'b110 || f3 == 3'b111)
                    : is_br  ? f3[2:1] == 2'b00
                    : 1'b0;
    // Indices beyond the implemented register count are illegal rather than aliased
    assign bad_reg = ((is_op || is_imm) && ({1'b0, rd} >= NR || {1'b0, rs1} >= NR)) ||
                     ((is_op || is_br) && ({1'b0, rs1} >= NR || {1'b0, rs2} >= NR));
    assign legal   = funct_ok && !bad_reg;

    // b already holds the immediate for I-type, so one ALU path serves both formats
    assign addsub = (is_op && f7[5]) ? a - b : a + b;
    assign alu    = f3 == 3'b000 ? addsub
                  : f3 == 3'b111 ? a & b
                  : f3 == 3'b110 ? a | b
                  : f3 == 3'b100 ? a ^ b
                  : f3 == 3'b010 ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)}
                  : {{(XLEN-1){1'b0}}, a < b};

    assign imem_addr = pc[IMEM_AW+1:2];
    assign dbg_data  = (dbg_sel == 5'd0 || {1'b0, dbg_sel} >= NR) ? '0 : regs[dbg_sel[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= XLEN'(PC_RESET);
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            npc      <= '0;
            step_q   <= 1'b0;
            imem_req <= 1'b0;
            retire   <= 1'b0;
            wb_en    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            // Edge detector runs in every state, so an edge outside IDLE is consumed and lost
            step_q <= step;
            retire <= 1'b0;
            wb_en  <= 1'b0;
            case (state)
                IDLE: if (run || (step && !step_q)) begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: if (imem_valid) begin
                    ir       <= imem_rdata;
                    imem_req <= 1'b0;
                    state    <= DECODE;
                end
                DECODE: begin
                    a       <= regs[rs1[AW-1:0]];
                    b       <= is_imm ? imm_i : regs[rs2[AW-1:0]];
                    state   <= (ir == 32'h0000_0073 || !legal) ? HALT : EXEC;
                    halted  <= ir == 32'h0000_0073 || !legal;
                    illegal <= ir != 32'h0000_0073 && !legal;
                end
                EXEC: begin
                    state   <= WB;
                    retire  <= 1'b1;
                    wb_en   <= !is_br && rd != 5'd0;
                    wb_addr <= is_br ? 5'd0 : rd;
                    wb_data <= alu;
                    npc     <= next_pc;
                end
                WB: begin
                    if (wb_en) regs[wb_addr[AW-1:0]] <= wb_data;
                    pc       <= npc;
                    state    <= run ? FETCH : IDLE;
                    imem_req <= run;
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_rv_core.sv
// tb_multicycle_rv_core: scoreboard bench for multicycle_rv_core
module tb_multicycle_rv_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        imem_req, imem_valid, retire, wb_en, halted, illegal;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata, pc, wb_data, dbg_data;
    logic [4:0]  wb_addr;
    logic [4:0]  dbg_sel = 5'd0;
    logic [31:0] mem [256];
    int          lat = 0, wcnt = 0, cyc = 0, n_ret = 0, prev_ret = 0, req_run = 0, last_req = 0;
    int          n_chk = 0, n_pass = 0;
    bit          chk_time = 1'b0;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_rv_core dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .pc(pc), .retire(retire), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .halted(halted), .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    assign imem_rdata = mem[imem_addr];
    assign imem_valid = imem_req && wcnt == lat;

    always @(posedge clk) begin
        wcnt <= (imem_req && !imem_valid) ? wcnt + 1 : 0;
        cyc  <= reset ? cyc + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ii(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] rr(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic push(input logic en, input logic [4:0] addr, input logic [31:0] data, input logic [31:0] p);
        exp_t e;
        e.en = en; e.addr = addr; e.data = data; e.pc = p;
        sb.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0073;
    endtask

    task automatic do_reset(input logic r, input int l);
        @(negedge clk);
        reset = 1'b0; run = r; step = 1'b0; lat = l;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_pc", pc, 32'd0);
        n_ret = 0; req_run = 0; last_req = 0;
        sb.delete();
        reset = 1'b1;
    endtask

    task automatic wait_halt(input int max);
        for (int i = 0; i < max && !halted; i++) @(negedge clk);
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (imem_req) req_run++;
            else if (req_run != 0) begin
                last_req = req_run;
                req_run = 0;
            end
            if (retire) begin
                if (sb.size() == 0) check("unexpected_retire", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wb_en", {31'd0, wb_en}, {31'd0, e.en});
                    check("retire_pc", pc, e.pc);
                    if (e.en) begin
                        check("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                        check("wb_data", wb_data, e.data);
                    end
                    if (chk_time) begin
                        check("cpi", n_ret == 0 ? cyc : cyc - prev_ret, lat + 4);
                        check("req_len", last_req, lat + 1);
                    end
                end
                prev_ret = cyc;
                n_ret++;
            end
        end
    end

    initial begin
        // Arithmetic program, zero wait, free-running
        clear_mem();
        mem[0] = ii(12'd5, 5'd0, 5'd1);
        mem[1] = ii(12'hFFD, 5'd0, 5'd2);
        mem[2] = rr(7'd0, 5'd2, 5'd1, 3'b010, 5'd3);
        mem[3] = rr(7'd0, 5'd2, 5'd1, 3'b011, 5'd4);
        mem[4] = rr(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5);
        chk_time = 1'b1;
        dbg_sel = 5'd1;
        do_reset(1'b1, 0);
        push(1'b1, 5'd1, 32'd5, 32'd0);
        push(1'b1, 5'd2, 32'hFFFF_FFFD, 32'd4);
        push(1'b1, 5'd3, 32'd0, 32'd8);
        push(1'b1, 5'd4, 32'd1, 32'd12);
        push(1'b1, 5'd5, 32'd8, 32'd16);
        for (int i = 0; i < 50 && !retire; i++) @(negedge clk);
        check("dbg_before_wb", dbg_data, 32'd0);
        @(negedge clk);
        check("dbg_after_wb", dbg_data, 32'd5);
        wait_halt(200);
        check("ecall_illegal", {31'd0, illegal}, 32'd0);
        check("ecall_pc", pc, 32'd20);
        step = 1'b1;
        repeat (10) @(negedge clk);
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("halt_pc_hold", pc, 32'd20);
        check("arith_retires", n_ret, 32'd5);
        check("arith_sb_empty", sb.size(), 32'd0);
        dbg_sel = 5'd2; #1 check("dbg_x2", dbg_data, 32'hFFFF_FFFD);
        dbg_sel = 5'd3; #1 check("dbg_x3", dbg_data, 32'd0);
        dbg_sel = 5'd4; #1 check("dbg_x4", dbg_data, 32'd1);
        dbg_sel = 5'd5; #1 check("dbg_x5", dbg_data, 32'd8);
        dbg_sel = 5'd0; #1 check("dbg_x0", dbg_data, 32'd0);

        // Single-step: two long pulses, then a second edge arriving mid-instruction
        clear_mem();
        mem[0] = ii(12'd7, 5'd0, 5'd1);
        mem[1] = ii(12'd1, 5'd1, 5'd2);
        mem[2] = ii(12'd1, 5'd2, 5'd3);
        chk_time = 1'b0;
        do_reset(1'b0, 0);
        push(1'b1, 5'd1, 32'd7, 32'd0);
        push(1'b1, 5'd2, 32'd8, 32'd4);
        push(1'b1, 5'd3, 32'd9, 32'd8);
        repeat (5) @(negedge clk);
        check("idle_no_retire", n_ret, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            repeat (10) @(negedge clk);
            step = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("step_retires", n_ret, 32'd2);
        check("step_pc", pc, 32'd8);
        check("step_idle_req", {31'd0, imem_req}, 32'd0);
        dbg_sel = 5'd2; #1 check("step_dbg_x2", dbg_data, 32'd8);
        step = 1'b1; @(negedge clk);
        step = 1'b0; @(negedge clk);
        step = 1'b1; @(negedge clk);
        step = 1'b0;
        repeat (15) @(negedge clk);
        check("step_discard_retires", n_ret, 32'd3);
        check("step_discard_pc", pc, 32'd12);
        check("step_not_halted", {31'd0, halted}, 32'd0);

        // Three wait states per fetch
        clear_mem();
        mem[0] = ii(12'd5, 5'd0, 5'd1);
        mem[1] = ii(12'hFFD, 5'd0, 5'd2);
        chk_time = 1'b1;
        do_reset(1'b1, 3);
        push(1'b1, 5'd1, 32'd5, 32'd0);
        push(1'b1, 5'd2, 32'hFFFF_FFFD, 32'd4);
        wait_halt(200);
        check("wait_retires", n_ret, 32'd2);
        dbg_sel = 5'd2; #1 check("wait_dbg_x2", dbg_data, 32'hFFFF_FFFD);

        // Reset in the middle of a stalled fetch drops the request at once
        do_reset(1'b1, 20);
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        #2 reset = 1'b0;
        #1 check("async_req_drop", {31'd0, imem_req}, 32'd0);

        // Illegal word
        clear_mem();
        mem[0] = 32'hFFFF_FFFF;
        do_reset(1'b1, 0);
        wait_halt(50);
        check("illegal_flag", {31'd0, illegal}, 32'd1);
        check("illegal_pc", pc, 32'd0);
        check("illegal_retires", n_ret, 32'd0);

        // ECALL at the first address
        clear_mem();
        do_reset(1'b1, 0);
        wait_halt(50);
        check("ecall0_illegal", {31'd0, illegal}, 32'd0);
        check("ecall0_pc", pc, 32'd0);

        // Write to x0 is suppressed but still retires
        clear_mem();
        mem[0] = ii(12'd7, 5'd0, 5'd0);
        do_reset(1'b1, 0);
        push(1'b0, 5'd0, 32'd7, 32'd0);
        wait_halt(50);
        check("x0_retires", n_ret, 32'd1);
        check("x0_pc", pc, 32'd4);
        dbg_sel = 5'd0; #1 check("x0_dbg", dbg_data, 32'd0);

        // BEQ x0,x0,-8 at 0x10
        clear_mem();
        mem[0] = ii(12'd1, 5'd0, 5'd1);
        mem[1] = ii(12'd2, 5'd0, 5'd2);
        mem[2] = ii(12'd3, 5'd0, 5'd3);
        mem[3] = ii(12'd4, 5'd0, 5'd4);
        mem[4] = 32'hFE00_0CE3;
        do_reset(1'b1, 0);
        push(1'b1, 5'd1, 32'd1, 32'd0);
        push(1'b1, 5'd2, 32'd2, 32'd4);
        push(1'b1, 5'd3, 32'd3, 32'd8);
        push(1'b1, 5'd4, 32'd4, 32'd12);
`ifdef BRANCH_EN
        push(1'b0, 5'd0, 32'd0, 32'd16);
        push(1'b1, 5'd3, 32'd3, 32'd8);
        for (int i = 0; i < 100 && n_ret < 5; i++) @(negedge clk);
        check("br_reached", n_ret >= 5 ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
        check("br_target_addr", {24'd0, imem_addr}, 32'd2);
        run = 1'b0;
        repeat (10) @(negedge clk);
        check("br_retires", n_ret, 32'd6);
        check("br_park_pc", pc, 32'd12);
        check("br_not_halted", {31'd0, halted}, 32'd0);
`else
        wait_halt(100);
        check("br_illegal", {31'd0, illegal}, 32'd1);
        check("br_illegal_pc", pc, 32'd16);
        check("br_retires", n_ret, 32'd4);
`endif
        check("final_sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
